// File: rtl/peak_finder.sv
// Pulse analyser: finds threshold-crossing pulses in a sample stream and measures peak, peak time, width and pile-up.
// Latency: a record is visible on out_valid one cycle after the sample that completes the hold-off.
// Backpressure: records queue in a FIFO_DEPTH-entry FIFO; a push into a full FIFO with no pop is dropped and counted.
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   input_data, threshold    one unsigned sample per cycle, compared strictly against threshold
//   out_amp/out_time/out_width/out_pileup  head record fields, meaningful while out_valid=1
//   out_valid, out_ready     valid/ready handshake; a pop happens when both are high
//   overflow, drop_count     sticky drop flag and saturating count of dropped records
module peak_finder #(
    parameter int DATA_W     = 16,
    parameter int TS_W       = 16,
    parameter int WID_W      = 8,
    parameter int HOLDOFF    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] input_data,
    input  logic [DATA_W-1:0] threshold,
    output logic [DATA_W-1:0] out_amp,
    output logic [TS_W-1:0]   out_time,
    output logic [WID_W-1:0]  out_width,
    output logic              out_pileup,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [7:0]        drop_count
);

    // FIFO_DEPTH must be a power of two (>=2) so the pointers wrap naturally.
    localparam int CNT_W  = $clog2(HOLDOFF + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [FCNT_W-1:0] FULL_CNT   = FCNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  LAST_BELOW = CNT_W'(HOLDOFF - 1);
    localparam logic [WID_W-1:0]  WIDTH_ONE  = WID_W'(1);

    typedef struct packed {
        logic [DATA_W-1:0] amp;
        logic [TS_W-1:0]   ts;
        logic [WID_W-1:0]  width;
        logic              pileup;
    } rec_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pulse measurement
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [TS_W-1:0]    r_ts;
    logic [DATA_W-1:0]  r_max;
    logic [TS_W-1:0]    r_max_ts;
    logic [WID_W-1:0]   r_width;
    logic               r_pileup;
    logic [CNT_W-1:0]   r_below_cnt;

    state_t             w_state_nxt;
    logic [DATA_W-1:0]  w_max_nxt;
    logic [TS_W-1:0]    w_max_ts_nxt;
    logic [WID_W-1:0]   w_width_nxt;
    logic               w_pileup_nxt;
    logic [CNT_W-1:0]   w_below_nxt;
    logic               w_push;

    logic               w_above;
    logic               w_higher;
    logic               w_lower;
    logic [WID_W-1:0]   w_width_inc;
    rec_t               w_rec;

    assign w_above  = input_data > threshold;
    assign w_higher = input_data > r_max;
    assign w_lower  = input_data < r_max;
    // Width saturates at all-ones rather than wrapping on very long pulses.
    assign w_width_inc = (r_width == '1) ? r_width : r_width + WIDTH_ONE;

    // The record is complete before the pushing sample arrives (that sample is
    // below threshold and cannot alter max, time or width).
    assign w_rec = '{amp: r_max, ts: r_max_ts, width: r_width, pileup: r_pileup};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ts        <= '0;
            r_max       <= '0;
            r_max_ts    <= '0;
            r_width     <= '0;
            r_pileup    <= 1'b0;
            r_below_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ts        <= r_ts + 1'b1;
            r_max       <= w_max_nxt;
            r_max_ts    <= w_max_ts_nxt;
            r_width     <= w_width_nxt;
            r_pileup    <= w_pileup_nxt;
            r_below_cnt <= w_below_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_max_nxt    = r_max;
        w_max_ts_nxt = r_max_ts;
        w_width_nxt  = r_width;
        w_pileup_nxt = r_pileup;
        w_below_nxt  = r_below_cnt;
        w_push       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_above) begin
                    w_state_nxt  = S_RISE;
                    w_max_nxt    = input_data;
                    w_max_ts_nxt = r_ts;
                    w_width_nxt  = WIDTH_ONE;
                    w_pileup_nxt = 1'b0;
                    w_below_nxt  = '0;
                end
            end

            S_RISE: begin
                if (w_above) begin
                    w_width_nxt = w_width_inc;
                end
                // Equal samples keep the earliest peak and stay in RISE.
                if (w_higher) begin
                    w_max_nxt    = input_data;
                    w_max_ts_nxt = r_ts;
                end else if (w_lower) begin
                    w_state_nxt = S_FALL;
                    w_below_nxt = '0;
                end
            end

            S_FALL: begin
                if (w_above) begin
                    w_below_nxt = '0;
                    w_width_nxt = w_width_inc;
                    if (w_higher) begin
                        w_max_nxt    = input_data;
                        w_max_ts_nxt = r_ts;
                        w_pileup_nxt = 1'b1;
                    end
                end else if (r_below_cnt == LAST_BELOW) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_below_nxt = '0;
                end else begin
                    w_below_nxt = r_below_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Record FIFO with a registered show-ahead head
    // ------------------------------------------------------------------
    rec_t              r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [FCNT_W-1:0] r_count;
    logic              r_valid;
    rec_t              r_head;
    logic              r_overflow;
    logic [7:0]        r_drop_count;

    logic              w_pop;
    logic              w_full;
    logic              w_accept;
    logic              w_drop;
    logic [PTR_W-1:0]  w_rptr_nxt;
    logic [FCNT_W-1:0] w_after_pop;
    logic [FCNT_W-1:0] w_count_nxt;
    rec_t              w_head_nxt;

    assign w_pop       = r_valid & out_ready;
    assign w_full      = (r_count == FULL_CNT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_accept    = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;
    assign w_rptr_nxt  = r_rptr + PTR_W'(w_pop);
    assign w_after_pop = r_count - FCNT_W'(w_pop);
    assign w_count_nxt = w_after_pop + FCNT_W'(w_accept);
    // If nothing older remains after the pop, the incoming record becomes the
    // head directly; otherwise the head is the next stored entry.
    assign w_head_nxt  = (w_after_pop == '0) ? w_rec : r_mem[w_rptr_nxt];

    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_mem[r_wptr] <= w_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_head       <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_head <= w_head_nxt;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
        end
    end

    assign out_amp    = r_head.amp;
    assign out_time   = r_head.ts;
    assign out_width  = r_head.width;
    assign out_pileup = r_head.pileup;
    assign out_valid  = r_valid;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_peak_finder.sv
module tb_peak_finder;

    localparam int HO    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] input_data = '0;
    logic [15:0] threshold = '0;
    logic [15:0] out_amp;
    logic [15:0] out_time;
    logic [7:0]  out_width;
    logic        out_pileup;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    peak_finder #(
        .DATA_W(16), .TS_W(16), .WID_W(8), .HOLDOFF(HO), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
        .out_amp(out_amp), .out_time(out_time), .out_width(out_width),
        .out_pileup(out_pileup), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .drop_count(drop_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int amp;
        int tm;
        int wid;
        int pile;
    } rec_t;

    rec_t mq[$];
    int   m_ts = 0;
    bit   m_ovf = 0;
    int   m_drops = 0;
    bit   active = 0;
    int   bx[$];
    int   bt[$];
    bit   ba[$];

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Judge the pulse from its whole sample history: it starts falling at the
    // first sample below the running max, and ends once the last HO samples,
    // all after that point, are not above threshold.
    task automatic model_step(input int x, input int thr, input bit rdy, input bit rst);
        bit   pop;
        bit   push;
        rec_t r;
        int   n, fi, runmax, mx, tidx, wid;
        bit   ended;
        if (rst) begin
            mq.delete(); bx.delete(); bt.delete(); ba.delete();
            active = 0; m_ts = 0; m_ovf = 0; m_drops = 0;
            return;
        end
        pop  = (mq.size() != 0) && rdy;
        push = 0;
        r    = '{0, 0, 0, 0};
        if (!active) begin
            if (x > thr) begin
                active = 1;
                bx.delete(); bt.delete(); ba.delete();
                bx.push_back(x); bt.push_back(m_ts); ba.push_back(1'b1);
            end
        end else begin
            bx.push_back(x); bt.push_back(m_ts); ba.push_back(x > thr);
            n = bx.size();
            fi = -1;
            runmax = bx[0];
            for (int i = 1; i < n; i++) begin
                if (bx[i] < runmax) begin
                    fi = i;
                    break;
                end
                if (bx[i] > runmax) runmax = bx[i];
            end
            ended = (fi >= 0) && ((n - 1 - fi) >= HO);
            if (ended) begin
                for (int j = n - HO; j < n; j++) if (ba[j]) ended = 0;
            end
            if (ended) begin
                mx = -1; tidx = 0; wid = 0;
                for (int i = 0; i < n; i++) begin
                    if (bx[i] > mx) begin
                        mx = bx[i];
                        tidx = i;
                    end
                    if (ba[i]) wid++;
                end
                r.amp  = mx;
                r.tm   = bt[tidx];
                r.wid  = (wid > 255) ? 255 : wid;
                r.pile = (tidx > fi) ? 1 : 0;
                push   = 1;
                active = 0;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        m_ts = (m_ts + 1) % 65536;
    endtask

    // Every cycle: DUT outputs against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("valid", out_valid, (mq.size() != 0) ? 1 : 0);
            if (mq.size() != 0) begin
                chk("amp", out_amp, mq[0].amp);
                chk("time", out_time, mq[0].tm);
                chk("width", out_width, mq[0].wid);
                chk("pileup", out_pileup, mq[0].pile);
            end
            chk("overflow", overflow, m_ovf ? 1 : 0);
            chk("drop_count", drop_count, m_drops);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int x, input int thr, input bit rdy, input bit rst);
        @(negedge clk);
        reset      = rst;
        input_data = 16'(x);
        threshold  = 16'(thr);
        out_ready  = rdy;
        model_step(x, thr, rdy, rst);
    endtask

    // Wait for the edge that applies the last step, then look at outputs.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Peak, then three zeros (fall + hold-off push on the third), then idle.
    task automatic pulse(input int p, input bit rdy_at_push);
        step(p, 100, 1'b0, 1'b0);
        step(0, 100, 1'b0, 1'b0);
        step(0, 100, 1'b0, 1'b0);
        step(0, 100, rdy_at_push, 1'b0);
        step(0, 100, 1'b0, 1'b0);
    endtask

    task automatic drain(input int first, input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            chk(nm, out_amp, first + 10 * k);
            step(0, 100, 1'b1, 1'b0);
            settle();
        end
        chk({nm, "_empty"}, out_valid, 0);
    endtask

    int s1[9] = '{0, 0, 50, 200, 400, 300, 150, 80, 0};
    int s2[9] = '{0, 200, 500, 300, 120, 700, 400, 50, 0};

    initial begin
        // Reset
        step(0, 100, 1'b1, 1'b1);
        chk_en = 1;
        step(0, 100, 1'b1, 1'b1);
        settle();
        chk("rst_valid", out_valid, 0);
        chk("rst_amp", out_amp, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drops", drop_count, 0);

        // Single pulse
        for (int i = 0; i < 9; i++) step(s1[i], 100, 1'b1, 1'b0);
        settle();
        chk("p1_valid", out_valid, 1);
        chk("p1_amp", out_amp, 400);
        chk("p1_time", out_time, 4);
        chk("p1_width", out_width, 4);
        chk("p1_pileup", out_pileup, 0);
        step(0, 100, 1'b1, 1'b0);
        settle();
        chk("p1_gone", out_valid, 0);

        // Pile-up
        step(0, 100, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(s2[i], 100, 1'b1, 1'b0);
        settle();
        chk("pu_amp", out_amp, 700);
        chk("pu_time", out_time, 5);
        chk("pu_width", out_width, 6);
        chk("pu_pileup", out_pileup, 1);
        step(0, 100, 1'b1, 1'b0);
        settle();
        chk("pu_single", out_valid, 0);

        // Backpressure and overflow
        step(0, 100, 1'b0, 1'b1);
        for (int p = 110; p <= 150; p += 10) pulse(p, 1'b0);
        settle();
        chk("bp_overflow", overflow, 1);
        chk("bp_drops", drop_count, 1);
        chk("bp_valid", out_valid, 1);
        drain(110, 4, "bp_drain");

        // Full FIFO with a pop in the same cycle as the push
        step(0, 100, 1'b0, 1'b1);
        for (int p = 210; p <= 240; p += 10) pulse(p, 1'b0);
        pulse(250, 1'b1);
        settle();
        chk("fp_overflow", overflow, 0);
        chk("fp_drops", drop_count, 0);
        drain(220, 4, "fp_drain");

        // Reset mid-pulse, then timestamps restart from 0
        step(0, 100, 1'b1, 1'b1);
        step(0, 100, 1'b1, 1'b0);
        step(200, 100, 1'b1, 1'b0);
        step(400, 100, 1'b1, 1'b1);
        settle();
        chk("rm_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) step(0, 100, 1'b1, 1'b0);
        step(300, 100, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 100, 1'b1, 1'b0);
        settle();
        chk("rm_amp", out_amp, 300);
        chk("rm_time", out_time, 3);
        chk("rm_width", out_width, 1);

        // Timestamp wrap and width saturation
        step(0, 100, 1'b1, 1'b1);
        for (int i = 0; i < 65530; i++) step(0, 100, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(500, 100, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 100, 1'b1, 1'b0);
        settle();
        chk("wr_amp", out_amp, 500);
        chk("wr_time", out_time, 65530);
        chk("wr_width", out_width, 255);
        chk("wr_pileup", out_pileup, 0);
        step(0, 100, 1'b1, 1'b0);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
